// File: rtl/ch1_sweep_freq_if.sv
// Channel 1 frequency-side bus: CPU register writes, sweep controls in, frequency/status out.
interface ch1_sweep_freq_if #(
    parameter int unsigned FREQ_W = 11
);
    logic [7:0]        d;
    logic              apu_wr;
    logic              ff13;
    logic              ff14;
    logic              nff10_d3;
    logic              ch1_restart;
    logic              ch1_ld_shift;
    logic              ch1_shift_clk;
    logic              ch1_freq_upd1;
    logic              ch1_freq_upd2;
    logic              ch1_freq_tick;
    logic [FREQ_W-1:0] ch1_freq;
    logic              ch1_sweep_ovf;
    logic              ch1_period_pulse;

    modport master (
        output d, apu_wr, ff13, ff14, nff10_d3,
        output ch1_restart, ch1_ld_shift, ch1_shift_clk,
        output ch1_freq_upd1, ch1_freq_upd2, ch1_freq_tick,
        input  ch1_freq, ch1_sweep_ovf, ch1_period_pulse
    );

    modport slave (
        input  d, apu_wr, ff13, ff14, nff10_d3,
        input  ch1_restart, ch1_ld_shift, ch1_shift_clk,
        input  ch1_freq_upd1, ch1_freq_upd2, ch1_freq_tick,
        output ch1_freq, ch1_sweep_ovf, ch1_period_pulse
    );
endinterface

// File: rtl/ch1_sweep_freq.sv
// Channel 1 frequency register, sweep shadow/adder with overflow kill, and period counter.
module ch1_sweep_freq #(
    parameter int unsigned FREQ_W = 11,
    parameter int unsigned SUM_W  = FREQ_W + 1
) (
    input logic             nphi,
    input logic             apu_reset,
    ch1_sweep_freq_if.slave bus
);
    localparam int unsigned HI_W = FREQ_W - 8;

    logic [FREQ_W-1:0] r_freq;
    logic [FREQ_W-1:0] r_shadow;
    logic [FREQ_W-1:0] r_cnt;
    logic              r_shift_dly;
    logic              r_upd1_dly;
    logic              r_upd2_dly;
    logic              r_ovf;
    logic              r_pulse;

    logic              w_shift_ev;
    logic              w_upd1_ev;
    logic              w_upd2_ev;
    logic              w_wr13;
    logic              w_wr14;
    logic              w_ovf_cond;
    logic [SUM_W-1:0]  w_freq_ext;
    logic [SUM_W-1:0]  w_shadow_ext;
    logic [SUM_W-1:0]  w_sum;

    always_comb begin
        w_shift_ev   = bus.ch1_shift_clk & ~r_shift_dly;
        w_upd1_ev    = bus.ch1_freq_upd1 & ~r_upd1_dly;
        w_upd2_ev    = bus.ch1_freq_upd2 & ~r_upd2_dly;
        w_wr13       = bus.apu_wr & bus.ff13;
        w_wr14       = bus.apu_wr & bus.ff14;
        w_freq_ext   = SUM_W'(r_freq);
        w_shadow_ext = SUM_W'(r_shadow);
        // Subtract wraps mod 2^SUM_W; only the add direction can flag overflow.
        w_sum        = bus.nff10_d3 ? (w_freq_ext + w_shadow_ext)
                                    : (w_freq_ext - w_shadow_ext);
        w_ovf_cond   = bus.nff10_d3 & w_sum[SUM_W-1];
    end

    always_ff @(posedge nphi) begin
        if (apu_reset) begin
            r_freq      <= '0;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_shift_dly <= 1'b0;
            r_upd1_dly  <= 1'b0;
            r_upd2_dly  <= 1'b0;
            r_ovf       <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_shift_dly <= bus.ch1_shift_clk;
            r_upd1_dly  <= bus.ch1_freq_upd1;
            r_upd2_dly  <= bus.ch1_freq_upd2;

            if (bus.ch1_restart || bus.ch1_ld_shift) begin
                r_shadow <= r_freq;
            end else if (w_shift_ev) begin
                r_shadow <= r_shadow >> 1;
            end

            // CPU writes beat a same-cycle sweep write-back.
            if (w_wr13 || w_wr14) begin
                if (w_wr13) r_freq[7:0] <= bus.d;
                if (w_wr14) r_freq[FREQ_W-1:8] <= bus.d[HI_W-1:0];
            end else if (w_upd1_ev && !w_ovf_cond) begin
                r_freq <= w_sum[FREQ_W-1:0];
            end

            if (bus.ch1_restart) begin
                r_ovf <= 1'b0;
            end else if ((w_upd1_ev || w_upd2_ev) && w_ovf_cond) begin
                r_ovf <= 1'b1;
            end

            r_pulse <= 1'b0;
            if (bus.ch1_restart) begin
                r_cnt <= r_freq;
            end else if (bus.ch1_freq_tick) begin
                if (&r_cnt) begin
                    r_cnt   <= r_freq;
                    r_pulse <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + FREQ_W'(1);
                end
            end
        end
    end

    assign bus.ch1_freq         = r_freq;
    assign bus.ch1_sweep_ovf    = r_ovf;
    assign bus.ch1_period_pulse = r_pulse;
endmodule

// File: tb/tb_ch1_sweep_freq.sv
// Scoreboard bench for ch1_sweep_freq: stimulus queues expected state, monitor compares each cycle.
module tb_ch1_sweep_freq;
    logic nphi = 1'b0;
    logic apu_reset;

    ch1_sweep_freq_if #(.FREQ_W(11)) bus ();

    ch1_sweep_freq #(
        .FREQ_W(11),
        .SUM_W (12)
    ) dut (
        .nphi     (nphi),
        .apu_reset(apu_reset),
        .bus      (bus)
    );

    always #5 nphi = ~nphi;

    typedef struct {
        string       tag;
        logic [10:0] freq;
        logic        ovf;
        logic        pulse;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    // Inputs are set by the caller; this samples them at the next edge and queues the result.
    task automatic cyc(input string tag, input logic [10:0] f, input logic o, input logic p);
        exp_t e;
        @(posedge nphi);
        e.tag   = tag;
        e.freq  = f;
        e.ovf   = o;
        e.pulse = p;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic clr_in();
        bus.d             = 8'h00;
        bus.apu_wr        = 1'b0;
        bus.ff13          = 1'b0;
        bus.ff14          = 1'b0;
        bus.ch1_restart   = 1'b0;
        bus.ch1_ld_shift  = 1'b0;
        bus.ch1_shift_clk = 1'b0;
        bus.ch1_freq_upd1 = 1'b0;
        bus.ch1_freq_upd2 = 1'b0;
        bus.ch1_freq_tick = 1'b0;
    endtask

    task automatic wr(input bit sel14, input logic [7:0] v, input string tag,
                      input logic [10:0] f, input logic o);
        bus.apu_wr = 1'b1;
        bus.ff13   = !sel14;
        bus.ff14   = sel14;
        bus.d      = v;
        cyc(tag, f, o, 1'b0);
        bus.apu_wr = 1'b0;
        bus.ff13   = 1'b0;
        bus.ff14   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        int   cycles;
        exp_t e;
        cycles = 0;
        forever begin
            @(negedge nphi);
            cycles++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".freq"}, bus.ch1_freq, e.freq);
                chk({e.tag, ".ovf"}, {10'd0, bus.ch1_sweep_ovf}, {10'd0, e.ovf});
                chk({e.tag, ".pulse"}, {10'd0, bus.ch1_period_pulse}, {10'd0, e.pulse});
            end else if (stim_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (cycles > 2000) begin
                total++;
                bad++;
                $display("FAIL watchdog: cycles %0d limit 2000", cycles);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        clr_in();
        bus.nff10_d3 = 1'b0;
        apu_reset    = 1'b1;

        // Reset with busy inputs
        bus.d = 8'hFF; bus.apu_wr = 1'b1; bus.ff13 = 1'b1; bus.ff14 = 1'b1;
        bus.nff10_d3 = 1'b1; bus.ch1_restart = 1'b1; bus.ch1_ld_shift = 1'b1;
        bus.ch1_shift_clk = 1'b1; bus.ch1_freq_upd1 = 1'b1; bus.ch1_freq_upd2 = 1'b1;
        bus.ch1_freq_tick = 1'b1;
        cyc("rst0", 11'h000, 1'b0, 1'b0);
        clr_in();
        bus.d = 8'h55; bus.apu_wr = 1'b1; bus.ff14 = 1'b1; bus.ch1_freq_upd2 = 1'b1;
        bus.ch1_shift_clk = 1'b1;
        cyc("rst1", 11'h000, 1'b0, 1'b0);
        clr_in();
        bus.nff10_d3 = 1'b0;
        apu_reset    = 1'b0;
        wr(1'b0, 8'h00, "wr13", 11'h000, 1'b0);
        wr(1'b1, 8'h01, "wr14", 11'h100, 1'b0);

        // Sweep add: shadow 0x080
        bus.nff10_d3 = 1'b1;
        bus.ch1_ld_shift = 1'b1;  cyc("add_ld", 11'h100, 1'b0, 1'b0);
        bus.ch1_ld_shift = 1'b0; bus.ch1_shift_clk = 1'b1;
        cyc("add_sh", 11'h100, 1'b0, 1'b0);
        bus.ch1_shift_clk = 1'b0; cyc("add_idle", 11'h100, 1'b0, 1'b0);
        bus.ch1_freq_upd1 = 1'b1; cyc("add_upd1", 11'h180, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc($sformatf("add_hold%0d", i), 11'h180, 1'b0, 1'b0);
        bus.ch1_freq_upd1 = 1'b0; cyc("add_rel", 11'h180, 1'b0, 1'b0);

        // Sweep subtract: shadow 0x040
        wr(1'b0, 8'h00, "sub_wr", 11'h100, 1'b0);
        bus.nff10_d3 = 1'b0;
        bus.ch1_ld_shift = 1'b1;  cyc("sub_ld", 11'h100, 1'b0, 1'b0);
        bus.ch1_ld_shift = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ch1_shift_clk = 1'b1; cyc("sub_sh", 11'h100, 1'b0, 1'b0);
            bus.ch1_shift_clk = 1'b0; cyc("sub_idle", 11'h100, 1'b0, 1'b0);
        end
        bus.ch1_freq_upd1 = 1'b1; cyc("sub_upd1", 11'h0C0, 1'b0, 1'b0);
        bus.ch1_freq_upd1 = 1'b0;

        // Overflow: 0x7F0 + 0x3F8 carries out
        wr(1'b0, 8'hF0, "ovf_wr13", 11'h0F0, 1'b0);
        wr(1'b1, 8'h07, "ovf_wr14", 11'h7F0, 1'b0);
        bus.nff10_d3 = 1'b1;
        bus.ch1_ld_shift = 1'b1;  cyc("ovf_ld", 11'h7F0, 1'b0, 1'b0);
        bus.ch1_ld_shift = 1'b0; bus.ch1_shift_clk = 1'b1;
        cyc("ovf_sh", 11'h7F0, 1'b0, 1'b0);
        bus.ch1_shift_clk = 1'b0; cyc("ovf_idle", 11'h7F0, 1'b0, 1'b0);
        bus.ch1_freq_upd2 = 1'b1; cyc("ovf_upd2", 11'h7F0, 1'b1, 1'b0);
        bus.ch1_freq_upd2 = 1'b0; bus.ch1_freq_upd1 = 1'b1;
        cyc("ovf_upd1", 11'h7F0, 1'b1, 1'b0);
        bus.ch1_freq_upd1 = 1'b0; bus.ch1_restart = 1'b1;
        cyc("ovf_restart", 11'h7F0, 1'b0, 1'b0);
        bus.ch1_restart = 1'b0;

        // Collisions: CPU write beats upd1; ld_shift beats shift_clk
        wr(1'b1, 8'h00, "col_wr14", 11'h0F0, 1'b0);
        bus.ch1_ld_shift = 1'b1;  cyc("col_ld", 11'h0F0, 1'b0, 1'b0);
        bus.ch1_ld_shift = 1'b0; bus.ch1_freq_upd1 = 1'b1;
        wr(1'b0, 8'h55, "col_wr_upd1", 11'h055, 1'b0);
        bus.ch1_freq_upd1 = 1'b0; bus.ch1_ld_shift = 1'b1; bus.ch1_shift_clk = 1'b1;
        cyc("col_ld_sh", 11'h055, 1'b0, 1'b0);
        bus.ch1_ld_shift = 1'b0; bus.ch1_shift_clk = 1'b0; bus.ch1_freq_upd1 = 1'b1;
        cyc("col_upd1", 11'h0AA, 1'b0, 1'b0);
        bus.ch1_freq_upd1 = 1'b0;

        // Period: 4 ticks at 0x7FC, new freq 0x7FE written mid-period
        wr(1'b0, 8'hFC, "per_wr13", 11'h0FC, 1'b0);
        wr(1'b1, 8'h07, "per_wr14", 11'h7FC, 1'b0);
        bus.ch1_restart = 1'b1;   cyc("per_restart", 11'h7FC, 1'b0, 1'b0);
        bus.ch1_restart = 1'b0;
        bus.ch1_freq_tick = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            logic [10:0] f;
            logic        p;
            if (k == 10) begin
                bus.apu_wr = 1'b1;
                bus.ff13   = 1'b1;
                bus.d      = 8'hFE;
            end
            f = (k >= 10) ? 11'h7FE : 11'h7FC;
            p = (k == 4) || (k == 8) || (k == 12) || (k == 14) || (k == 16) || (k == 18);
            cyc($sformatf("per_tick%0d", k), f, 1'b0, p);
            bus.apu_wr = 1'b0;
            bus.ff13   = 1'b0;
        end
        bus.ch1_freq_tick = 1'b0;
        cyc("per_stop", 11'h7FE, 1'b0, 1'b0);
        stim_done = 1'b1;
    end
endmodule

// File: doc/ch1_sweep_freq.md
Name: ch1_sweep_freq

Overview:
Frequency side of channel 1: the 11-bit frequency register, the sweep shadow shift register, the add/subtract unit with overflow check, and the period counter. It is the responder to the channel 1 sweep control signals (ch1_restart, ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2). It returns the current frequency, a sweep-overflow kill signal and the period pulse that clocks the duty sequencer.

Parameters:
FREQ_W, 11, width of frequency, shadow and period counter
SUM_W, 12, width of sweep adder result (FREQ_W+1)

Ports:
nphi  input  1  system clock; all state updates on rising edge
apu_reset  input  1  synchronous, active-high reset
d  input  8  CPU data bus
apu_wr  input  1  CPU write strobe, qualified by the register selects
ff13  input  1  NR13 select; write loads freq[7:0]
ff14  input  1  NR14 select; write loads freq[10:8] from d[2:0]
nff10_d3  input  1  sweep direction, inverted: 0 = subtract, 1 = add
ch1_restart  input  1  trigger, level, one or more cycles
ch1_ld_shift  input  1  level; while high, shadow follows freq
ch1_shift_clk  input  1  each rising edge, sampled on nphi, shifts shadow right by 1
ch1_freq_upd1  input  1  rising edge: write sum back into freq, or flag overflow
ch1_freq_upd2  input  1  rising edge: overflow recheck only
ch1_freq_tick  input  1  1-cycle enable at the period counter rate
ch1_freq  output  11  current frequency register
ch1_sweep_ovf  output  1  sticky overflow; channel disables itself while high
ch1_period_pulse  output  1  1-cycle pulse on period counter wrap

Behaviour:
- Reset (apu_reset high at an edge): freq=0, shadow=0, period counter=0, all edge-detect flops=0, ch1_sweep_ovf=0, ch1_period_pulse=0. Reset overrides every other event in the same cycle.
- Edge detection: one flop per input for ch1_shift_clk, ch1_freq_upd1 and ch1_freq_upd2. An event is "input high and flop low". The action takes effect at the same edge that samples the rise. Latency is 1 nphi cycle from the input going high to the register update.
- Sum (combinational):
  - nff10_d3=1: sum = {0,freq} + {0,shadow}
  - nff10_d3=0: sum = {0,freq} - {0,shadow}, mod 2^SUM_W
  - ovf_cond = nff10_d3 & sum[11]
  - Subtraction never sets ovf_cond. If it wraps (freq rewritten after load), sum[10:0] is used unchanged.
- Shadow register. Priority, highest first:
  1. restart or ld_shift high: shadow <= freq
  2. shift event: shadow <= shadow >> 1, zero fill
  - Shifting a zero shadow holds 0.
- freq register. Priority, highest first:
  1. CPU write: apu_wr&ff13 loads freq[7:0]=d; apu_wr&ff14 loads freq[10:8]=d[2:0]. Both selects in one cycle apply both fields.
  2. upd1 event with !ovf_cond: freq <= sum[10:0]
  - A CPU write and an upd1 event in the same cycle: the CPU write wins and the sum is discarded.
- ch1_sweep_ovf:
  - Set by an upd1 or upd2 event when ovf_cond=1.
  - Cleared by ch1_restart. Restart has priority over set in the same cycle.
  - Held otherwise.
  - upd1 with overflow leaves freq unchanged.
- Period counter (11-bit, up-counting):
  - ch1_restart: cnt <= freq, and no pulse is emitted.
  - Otherwise, on tick:
    - cnt==0x7FF: cnt <= freq, ch1_period_pulse=1 for exactly one nphi cycle.
    - cnt!=0x7FF: cnt <= cnt+1.
  - Period = 2048 - freq ticks. freq=0x7FF gives a pulse on every tick.
  - A freq change mid-period takes effect at the next reload.
- ch1_freq is the register output directly, with no extra latency.
- Input levels held high cause no repeated events; only fresh rising edges count.

Test Plan:
1. Reset check: hold apu_reset 2 cycles with all inputs toggling -> ch1_freq=0, ovf=0, no pulse. Release, write ff13=0x00 and ff14=0x01 -> ch1_freq=0x100 one cycle after the write.
2. Sweep add: freq=0x100, nff10_d3=1, pulse ld_shift, 1 shift_clk edge (shadow=0x080), upd1 edge -> freq=0x180, ovf=0. Holding upd1 high 5 cycles gives no second update.
3. Sweep subtract: freq=0x100, nff10_d3=0, ld_shift, 2 shift edges (shadow=0x040), upd1 -> freq=0x0C0, ovf=0.
4. Overflow:
   - freq=0x7F0, add, ld_shift, 1 shift (shadow=0x3F8), upd2 -> ovf=1, freq=0x7F0 unchanged.
   - upd1 -> freq still 0x7F0.
   - ch1_restart -> ovf=0.
5. Collision: upd1 edge in the same cycle as a CPU ff13 write of 0x55 with freq[10:8]=0 -> freq=0x055, sum dropped. shift_clk and ld_shift together -> shadow=freq.
6. Period: freq=0x7FC, restart, continuous ticks -> a pulse every 4 ticks, each 1 cycle wide. Write freq=0x7FE mid-period -> the current period completes at 4 ticks, then pulses every 2 ticks.
